// File: rtl/tuner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tuner_pkg
// Description : Constants and state encoding shared by the tuner and its
//               hop controller.
// Revision    : 1.0 - initial release
// ============================================================================
package tuner_pkg;

    localparam int FSZ     = 31;       // tuning word width
    localparam int DSZ     = 16;       // tuner sample width
    localparam int ENTRY_W = FSZ + 1;  // hop entry: {freq, dir}

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DWELL  = 2'd3
    } hop_state_t;

endpackage
`default_nettype wire

// File: rtl/hop_table.sv
`default_nettype none
// ============================================================================
// Module      : hop_table
// Description : DEPTH x W register file, synchronous write, asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
module hop_table
    import tuner_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int W     = ENTRY_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] r_mem [DEPTH];

    // No reset: contents are undefined until software programs them.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Combinational read returns the pre-write value on a same-edge write.
    assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/tuner_hop_controller.sv
`default_nettype none
// ============================================================================
// Module      : tuner_hop_controller
// Description : Steps the tuner LO through a programmable hop table, blanking
//               out_valid for SETTLE cycles after every retune.
// Revision    : 1.0 - initial release
// ============================================================================
module tuner_hop_controller
    import tuner_pkg::*;
#(
    parameter int FSZ    = 31,
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int DWW    = 24,
    parameter int SETTLE = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cfg_we,
    input  logic [AW-1:0]  cfg_addr,
    input  logic [FSZ-1:0] cfg_freq,
    input  logic           cfg_dir,
    input  logic [AW-1:0]  last_idx,
    input  logic [DWW-1:0] dwell,
    input  logic           loop_en,
    input  logic           ns_en,
    input  logic           start,
    input  logic           stop,
    output logic [FSZ-1:0] lo_freq,
    output logic           lo_dir,
    output logic           lo_ns_en,
    output logic [AW-1:0]  hop_idx,
    output logic           hop_strobe,
    output logic           out_valid,
    output logic           busy,
    output logic           done
);

    localparam logic [AW-1:0]  C_LAST_MAX  = AW'(DEPTH - 1);
    localparam logic [DWW-1:0] C_SETTLE_M1 = DWW'(SETTLE - 1);

    hop_state_t     r_state, w_state_nxt;
    logic [AW-1:0]  r_idx, w_idx_nxt;
    logic [DWW-1:0] r_cnt, w_cnt_nxt;
    logic           r_loop_en, w_loop_nxt;
    logic           w_load, w_done_nxt;
    logic [AW-1:0]  w_last;
    logic [DWW-1:0] w_dwell_m1;
    logic [FSZ:0]   w_rd_entry;

    hop_table #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (FSZ + 1)
    ) u_hop_table (
        .clk     (clk),
        .we      (cfg_we),
        .wr_addr (cfg_addr),
        .wr_data ({cfg_freq, cfg_dir}),
        .rd_addr (r_idx),
        .rd_data (w_rd_entry)
    );

    assign w_last     = (last_idx > C_LAST_MAX) ? C_LAST_MAX : last_idx;
    assign w_dwell_m1 = (dwell == '0) ? '0 : dwell - DWW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_loop_nxt  = r_loop_en;
        w_load      = 1'b0;
        w_done_nxt  = 1'b0;
        // stop wins over everything, including a coincident start in IDLE
        if (stop) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_nxt = ST_LOAD;
                        w_idx_nxt   = '0;
                    end
                end
                ST_LOAD: begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = C_SETTLE_M1;
                    w_state_nxt = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_cnt == '0) begin
                        w_cnt_nxt   = w_dwell_m1;
                        w_loop_nxt  = loop_en;
                        w_state_nxt = ST_DWELL;
                    end else begin
                        w_cnt_nxt = r_cnt - DWW'(1);
                    end
                end
                ST_DWELL: begin
                    if (r_cnt == '0) begin
                        if ((r_idx == w_last) && !r_loop_en) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_idx_nxt   = (r_idx == w_last) ? '0 : r_idx + AW'(1);
                            w_state_nxt = ST_LOAD;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - DWW'(1);
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_loop_en  <= 1'b0;
            lo_freq    <= '0;
            lo_dir     <= 1'b0;
            lo_ns_en   <= 1'b0;
            hop_idx    <= '0;
            hop_strobe <= 1'b0;
            done       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_cnt      <= w_cnt_nxt;
            r_loop_en  <= w_loop_nxt;
            lo_ns_en   <= ns_en;
            hop_strobe <= w_load;
            done       <= w_done_nxt;
            if (w_load) begin
                lo_freq <= w_rd_entry[FSZ:1];
                lo_dir  <= w_rd_entry[0];
                hop_idx <= r_idx;
            end
        end
    end

    assign out_valid = (r_state == ST_DWELL);
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tuner_hop_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_tuner_hop_controller
// Description : Directed self-checking bench for tuner_hop_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tuner_hop_controller;

    localparam int FSZ = 31;
    localparam int AW  = 3;
    localparam int DWW = 24;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           cfg_we = 1'b0;
    logic [AW-1:0]  cfg_addr = '0;
    logic [FSZ-1:0] cfg_freq = '0;
    logic           cfg_dir = 1'b0;
    logic [AW-1:0]  last_idx = '0;
    logic [DWW-1:0] dwell = '0;
    logic           loop_en = 1'b0;
    logic           ns_en = 1'b0;
    logic           start = 1'b0;
    logic           stop = 1'b0;
    logic [FSZ-1:0] lo_freq;
    logic           lo_dir, lo_ns_en, hop_strobe, out_valid, busy, done;
    logic [AW-1:0]  hop_idx;

    int n_checks = 0;
    int n_fail   = 0;

    tuner_hop_controller #(
        .FSZ(FSZ), .DEPTH(8), .AW(AW), .DWW(DWW), .SETTLE(4)
    ) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_freq(cfg_freq), .cfg_dir(cfg_dir), .last_idx(last_idx),
        .dwell(dwell), .loop_en(loop_en), .ns_en(ns_en), .start(start),
        .stop(stop), .lo_freq(lo_freq), .lo_dir(lo_dir), .lo_ns_en(lo_ns_en),
        .hop_idx(hop_idx), .hop_strobe(hop_strobe), .out_valid(out_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic write_entry(input logic [AW-1:0] a, input logic [FSZ-1:0] f, input logic d);
        cfg_we = 1'b1; cfg_addr = a; cfg_freq = f; cfg_dir = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Returns at the negedge where the controller sits in LOAD (k = 1).
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++; if ({busy, out_valid, hop_strobe, done} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", {busy, out_valid, hop_strobe, done}); end
        n_checks++; if (lo_freq !== '0) begin n_fail++; $display("FAIL reset_lo_freq got %h exp 0", lo_freq); end
        n_checks++; if ({lo_dir, lo_ns_en, hop_idx} !== 5'b0) begin n_fail++; $display("FAIL reset_lo_misc got %b exp 0", {lo_dir, lo_ns_en, hop_idx}); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b exp 0", busy); end
        n_checks++; if (lo_freq !== '0) begin n_fail++; $display("FAIL idle_lo_freq got %h exp 0", lo_freq); end
        ns_en = 1'b1;
        @(negedge clk);
        n_checks++; if (lo_ns_en !== 1'b1) begin n_fail++; $display("FAIL ns_en_pass got %b exp 1", lo_ns_en); end
        ns_en = 1'b0;
        @(negedge clk);
        n_checks++; if (lo_ns_en !== 1'b0) begin n_fail++; $display("FAIL ns_en_clear got %b exp 0", lo_ns_en); end
    endtask

    // Expectations for a 3-entry pass with SETTLE=4, dwell=5: period 10,
    // strobe at k=2,12,22, valid k=6..10/16..20/26..30, done at k=31.
    task automatic check_pass3(input int k, input logic [FSZ-1:0] f1, input string tag);
        logic           e_strobe, e_valid, e_done, e_busy, e_dir;
        logic [FSZ-1:0] e_freq;
        logic [AW-1:0]  e_idx;
        e_strobe = (k == 2) || (k == 12) || (k == 22);
        e_valid  = (k >= 6 && k <= 10) || (k >= 16 && k <= 20) || (k >= 26 && k <= 30);
        e_done   = (k == 31);
        e_busy   = (k <= 30);
        n_checks++; if (hop_strobe !== e_strobe) begin n_fail++; $display("FAIL %s_strobe k=%0d got %b exp %b", tag, k, hop_strobe, e_strobe); end
        n_checks++; if (out_valid !== e_valid) begin n_fail++; $display("FAIL %s_valid k=%0d got %b exp %b", tag, k, out_valid, e_valid); end
        n_checks++; if (done !== e_done) begin n_fail++; $display("FAIL %s_done k=%0d got %b exp %b", tag, k, done, e_done); end
        n_checks++; if (busy !== e_busy) begin n_fail++; $display("FAIL %s_busy k=%0d got %b exp %b", tag, k, busy, e_busy); end
        if (k >= 2) begin
            e_freq = (k < 12) ? 31'h1000 : (k < 22) ? f1 : 31'h3000;
            e_dir  = (k >= 12 && k < 22);
            e_idx  = (k < 12) ? 3'd0 : (k < 22) ? 3'd1 : 3'd2;
            n_checks++; if (lo_freq !== e_freq) begin n_fail++; $display("FAIL %s_freq k=%0d got %h exp %h", tag, k, lo_freq, e_freq); end
            n_checks++; if (lo_dir !== e_dir) begin n_fail++; $display("FAIL %s_dir k=%0d got %b exp %b", tag, k, lo_dir, e_dir); end
            n_checks++; if (hop_idx !== e_idx) begin n_fail++; $display("FAIL %s_idx k=%0d got %0d exp %0d", tag, k, hop_idx, e_idx); end
        end
    endtask

    task automatic test_single_pass();
        write_entry(3'd0, 31'h1000, 1'b0);
        write_entry(3'd1, 31'h2000, 1'b1);
        write_entry(3'd2, 31'h3000, 1'b0);
        last_idx = 3'd2; dwell = 24'd5; loop_en = 1'b0;
        pulse_start();
        for (int k = 1; k <= 34; k++) begin
            check_pass3(k, 31'h2000, "single");
            @(negedge clk);
        end
    endtask

    task automatic test_loop_stop();
        int             hop;
        logic [FSZ-1:0] e_freq;
        loop_en = 1'b1;
        pulse_start();
        for (int k = 1; k <= 37; k++) begin
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL loop_done k=%0d got %b exp 0", k, done); end
            n_checks++; if (hop_strobe !== (k >= 2 && (k - 2) % 10 == 0)) begin n_fail++; $display("FAIL loop_strobe k=%0d got %b", k, hop_strobe); end
            n_checks++; if (out_valid !== (k >= 6 && (k - 6) % 10 < 5)) begin n_fail++; $display("FAIL loop_valid k=%0d got %b", k, out_valid); end
            if (k >= 2) begin
                hop    = ((k - 2) / 10) % 3;
                e_freq = (hop == 0) ? 31'h1000 : (hop == 1) ? 31'h2000 : 31'h3000;
                n_checks++; if (lo_freq !== e_freq) begin n_fail++; $display("FAIL loop_freq k=%0d got %h exp %h", k, lo_freq, e_freq); end
            end
            if (k == 37) stop = 1'b1;
            @(negedge clk);
        end
        stop = 1'b0;
        n_checks++; if ({busy, out_valid, done} !== 3'b000) begin n_fail++; $display("FAIL stop_flags got %b exp 000", {busy, out_valid, done}); end
        n_checks++; if (lo_freq !== 31'h1000) begin n_fail++; $display("FAIL stop_hold got %h exp 1000", lo_freq); end
        n_checks++; if (hop_idx !== 3'd0) begin n_fail++; $display("FAIL stop_idx got %0d exp 0", hop_idx); end
    endtask

    task automatic test_dwell_zero();
        dwell = 24'd0; last_idx = 3'd1; loop_en = 1'b0;
        @(negedge clk);
        pulse_start();
        for (int k = 1; k <= 14; k++) begin
            n_checks++; if (hop_strobe !== (k == 2 || k == 8)) begin n_fail++; $display("FAIL dw0_strobe k=%0d got %b", k, hop_strobe); end
            n_checks++; if (out_valid !== (k == 6 || k == 12)) begin n_fail++; $display("FAIL dw0_valid k=%0d got %b", k, out_valid); end
            n_checks++; if (done !== (k == 13)) begin n_fail++; $display("FAIL dw0_done k=%0d got %b", k, done); end
            if (k >= 2) begin
                n_checks++; if (lo_freq !== ((k < 8) ? 31'h1000 : 31'h2000)) begin n_fail++; $display("FAIL dw0_freq k=%0d got %h", k, lo_freq); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        dwell = 24'd5; last_idx = 3'd2; loop_en = 1'b0;
        pulse_start();
        for (int k = 1; k <= 32; k++) begin
            check_pass3(k, 31'h7777, "b2b");
            start = (k == 3);
            if (k == 4) begin
                cfg_we = 1'b1; cfg_addr = 3'd1; cfg_freq = 31'h7777; cfg_dir = 1'b1;
            end else begin
                cfg_we = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL startstop_busy got %b exp 0", busy); end
        @(negedge clk);
        n_checks++; if ({busy, hop_strobe} !== 2'b00) begin n_fail++; $display("FAIL startstop_after got %b exp 00", {busy, hop_strobe}); end
    endtask

    task automatic test_reset_mid();
        write_entry(3'd1, 31'h2000, 1'b1);
        pulse_start();
        for (int k = 1; k < 14; k++) @(negedge clk);
        n_checks++; if (hop_idx !== 3'd1) begin n_fail++; $display("FAIL rmid_pre_idx got %0d exp 1", hop_idx); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if ({busy, out_valid, done, hop_strobe} !== 4'b0) begin n_fail++; $display("FAIL rmid_flags got %b exp 0000", {busy, out_valid, done, hop_strobe}); end
        n_checks++; if ({lo_freq, lo_dir, hop_idx} !== '0) begin n_fail++; $display("FAIL rmid_lo got %h/%b/%0d exp 0", lo_freq, lo_dir, hop_idx); end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL rmid_idle k=%0d got %b exp 00", k, {busy, done}); end
        end
        pulse_start();
        @(negedge clk);
        n_checks++; if ({hop_strobe, hop_idx} !== {1'b1, 3'd0}) begin n_fail++; $display("FAIL restart_idx got %b/%0d exp 1/0", hop_strobe, hop_idx); end
        n_checks++; if (lo_freq !== 31'h1000) begin n_fail++; $display("FAIL restart_freq got %h exp 1000", lo_freq); end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_loop_stop();
        test_dwell_zero();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
